piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer_pkg.sv | 23 ++
 rtl/piso_serializer_if.sv | 33 +++
 rtl/piso_serializer_bit_reorder.sv | 38 +++
 rtl/piso_serializer.sv | 119 +++++++++++
 tb/tb_piso_serializer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Package     : piso_pkg
// Description : Shared types for the PISO serializer: the frame-sequencer
//               state encoding and the bit-counter width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Counter must be able to hold the value DATA_W, hence the +1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
// Interface   : piso_serializer_if
// Description : Parallel-word handshake plus serial frame outputs.
// Signals     : data[DATA_W] / data_valid  - word offered by the producer
//               data_ready                  - word accepted when valid&ready
//               out / latch / done          - serial bit, frame-bit strobe,
//                                             last-bit pulse
// Modports    : master - producer/consumer side (testbench or system)
//               slave  - serializer side
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              data_ready;
  logic              out;
  logic              latch;
  logic              done;

  modport master (
    output data, data_valid,
    input  data_ready, out, latch, done
  );

  modport slave (
    input  data, data_valid,
    output data_ready, out, latch, done
  );
endinterface
`default_nettype wire

// File: rtl/piso_serializer_bit_reorder.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_reorder
// Description : Combinational map from the parallel word to emission order.
//               Output bit [DATA_W-1] is the first bit to go out, so the
//               serializer can always shift MSB-first.
// Ports       : data      in  [DATA_W]  parallel word
//               reordered out [DATA_W]  word in emission order (MSB first)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_reorder #(
  parameter int DATA_W    = 16,
  parameter int BYTE_SWAP = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] reordered
);

  // k is the emission slot: slot 0 goes out first.
  for (genvar k = 0; k < DATA_W; k++) begin : g_bit
    if (BYTE_SWAP != 0) begin : g_bytes
      if (MSB_FIRST != 0) begin : g_msb
        assign reordered[DATA_W-1-k] = data[(k/8)*8 + 7 - (k%8)];
      end else begin : g_lsb
        assign reordered[DATA_W-1-k] = data[(k/8)*8 + (k%8)];
      end
    end else begin : g_word
      if (MSB_FIRST != 0) begin : g_msb
        assign reordered[DATA_W-1-k] = data[DATA_W-1-k];
      end else begin : g_lsb
        assign reordered[DATA_W-1-k] = data[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out framer. Captures a word in IDLE,
//               emits DATA_W bits (optionally followed by an even-parity
//               bit) one per cycle, then returns to IDLE for one cycle.
// Ports       : clk    in   rising-edge clock
//               rst_n  in   synchronous active-low reset
//               bus    slave modport of piso_serializer_if
// Options     : PISO_SERIALIZER_PARITY_EN - append even-parity bit
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BYTE_SWAP = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_serializer_if.slave     bus
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   reordered;
  logic                ser_out, frame_latch, frame_done;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic                parity_q, parity_d;
`endif

  piso_bit_reorder #(
    .DATA_W    (DATA_W),
    .BYTE_SWAP (BYTE_SWAP),
    .MSB_FIRST (MSB_FIRST)
  ) u_reorder (
    .data      (bus.data),
    .reordered (reordered)
  );

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    ser_out     = 1'b0;
    frame_latch = 1'b0;
    frame_done  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.data_valid) begin
          shreg_d = reordered;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef PISO_SERIALIZER_PARITY_EN
          parity_d = ^bus.data;
`endif
        end
      end
      SHIFT: begin
        ser_out     = shreg_q[DATA_W-1];
        frame_latch = 1'b1;
        shreg_d     = shreg_q << 1;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = PARITY;
`else
          frame_done = 1'b1;
          state_d    = IDLE;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        ser_out     = parity_q;
        frame_latch = 1'b1;
        frame_done  = 1'b1;
        state_d     = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Ready is gated by rst_n so nothing is offered as accepted during reset.
  assign bus.data_ready = (state_q == IDLE) && rst_n;
  assign bus.out        = ser_out;
  assign bus.latch      = frame_latch;
  assign bus.done       = frame_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Two instances run
//               side by side: A (BYTE_SWAP=1, MSB_FIRST=1) and
//               B (BYTE_SWAP=0, MSB_FIRST=0). Honours
//               PISO_SERIALIZER_PARITY_EN for the parity bit.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int DATA_W = 16;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  typedef struct {
    logic [15:0] data;
    logic [15:0] seq_a;   // emission order for A, bit 15 = first bit out
    logic [15:0] seq_b;   // emission order for B, bit 15 = first bit out
    logic        par;     // even parity of data
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t vecs[6];

  piso_serializer_if #(.DATA_W(DATA_W)) bus_a ();
  piso_serializer_if #(.DATA_W(DATA_W)) bus_b ();

  piso_serializer #(.DATA_W(DATA_W), .BYTE_SWAP(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  piso_serializer #(.DATA_W(DATA_W), .BYTE_SWAP(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] d, input logic v);
    bus_a.data = d; bus_a.data_valid = v;
    bus_b.data = d; bus_b.data_valid = v;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " latch_a"}, bus_a.latch, 0);
    check({tag, " out_a"},   bus_a.out, 0);
    check({tag, " done_a"},  bus_a.done, 0);
    check({tag, " ready_a"}, bus_a.data_ready, 1);
    check({tag, " latch_b"}, bus_b.latch, 0);
    check({tag, " ready_b"}, bus_b.data_ready, 1);
  endtask

  // One full frame; data is scrambled right after capture to show it is ignored.
  task automatic send_frame(input vec_t v);
    logic ea, eb;
    @(negedge clk);
    drive(v.data, 1'b1);
    @(posedge clk);
    #1;
    drive(~v.data, 1'b0);
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk);
      if (k < DATA_W) begin
        ea = v.seq_a[15-k];
        eb = v.seq_b[15-k];
      end else begin
        ea = v.par;
        eb = v.par;
      end
      check($sformatf("%h out_a[%0d]", v.data, k), bus_a.out, ea);
      check($sformatf("%h out_b[%0d]", v.data, k), bus_b.out, eb);
      check($sformatf("%h latch_a[%0d]", v.data, k), bus_a.latch, 1);
      check($sformatf("%h done_a[%0d]", v.data, k), bus_a.done, (k == FRAME_LEN-1) ? 1 : 0);
      check($sformatf("%h done_b[%0d]", v.data, k), bus_b.done, (k == FRAME_LEN-1) ? 1 : 0);
    end
    @(negedge clk);
    check_idle($sformatf("%h post", v.data));
  endtask

  initial begin
    int bad_resume;
    vecs[0] = '{data: 16'hA5C3, seq_a: 16'hC3A5, seq_b: 16'hC3A5, par: 1'b0};
    vecs[1] = '{data: 16'h0001, seq_a: 16'h0100, seq_b: 16'h8000, par: 1'b1};
    vecs[2] = '{data: 16'h1234, seq_a: 16'h3412, seq_b: 16'h2C48, par: 1'b1};
    vecs[3] = '{data: 16'h8000, seq_a: 16'h0080, seq_b: 16'h0001, par: 1'b1};
    vecs[4] = '{data: 16'hFFFF, seq_a: 16'hFFFF, seq_b: 16'hFFFF, par: 1'b0};
    vecs[5] = '{data: 16'h0000, seq_a: 16'h0000, seq_b: 16'h0000, par: 1'b0};

    // Reset state: valid offered during reset must not be accepted.
    drive(16'hFFFF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready_a", bus_a.data_ready, 0);
    check("rst ready_b", bus_b.data_ready, 0);
    check("rst latch_a", bus_a.latch, 0);
    check("rst out_a",   bus_a.out, 0);
    check("rst done_a",  bus_a.done, 0);
    drive(16'h0000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("release");

    // Table-driven frames.
    for (int i = 0; i < 6; i++) send_frame(vecs[i]);

    // Back-to-back frames with valid held high: FFFF then 0000.
    @(negedge clk);
    drive(16'hFFFF, 1'b1);
    @(posedge clk);
    #1;
    drive(16'h0000, 1'b1);
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk);
      check($sformatf("b2b1 out_a[%0d]", k), bus_a.out, (k < DATA_W) ? 1 : 0);
      check($sformatf("b2b1 latch_a[%0d]", k), bus_a.latch, 1);
      check($sformatf("b2b1 out_b[%0d]", k), bus_b.out, (k < DATA_W) ? 1 : 0);
    end
    @(negedge clk);
    check("b2b gap latch_a", bus_a.latch, 0);
    check("b2b gap ready_a", bus_a.data_ready, 1);
    check("b2b gap latch_b", bus_b.latch, 0);
    @(posedge clk);
    #1;
    drive(16'h0000, 1'b0);
    for (int k = 0; k < FRAME_LEN; k++) begin
      @(negedge clk);
      check($sformatf("b2b2 out_a[%0d]", k), bus_a.out, 0);
      check($sformatf("b2b2 latch_a[%0d]", k), bus_a.latch, 1);
      check($sformatf("b2b2 done_a[%0d]", k), bus_a.done, (k == FRAME_LEN-1) ? 1 : 0);
    end
    @(negedge clk);
    check_idle("b2b end");

    // Reset asserted at the edge after the 5th bit of a 1234 frame.
    @(negedge clk);
    drive(16'h1234, 1'b1);
    @(posedge clk);
    #1;
    drive(16'h0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("abort out_a[%0d]", k), bus_a.out, vecs[2].seq_a[15-k]);
      check($sformatf("abort out_b[%0d]", k), bus_b.out, vecs[2].seq_b[15-k]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort latch_a", bus_a.latch, 0);
    check("abort out_a",   bus_a.out, 0);
    check("abort done_a",  bus_a.done, 0);
    check("abort ready_a", bus_a.data_ready, 0);
    check("abort latch_b", bus_b.latch, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort release ready_a", bus_a.data_ready, 1);
    check("abort release ready_b", bus_b.data_ready, 1);
    bad_resume = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus_a.latch || bus_a.done || bus_b.latch || bus_b.done) bad_resume++;
    end
    check("abort no resume", bad_resume, 0);

    // A normal frame still works after the abort.
    send_frame(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
